// File: rtl/spi_shift_in_pkg.sv
// Shared SPI constants and receive-FIFO operation encoding.
// spi_shift_out imports the same constants.
package spi_shift_in_pkg;

   localparam int unsigned SPI_SDEPTH = 8;
   localparam int unsigned SPI_FDEPTH = 2;
   localparam int unsigned SPI_CWIDTH = $clog2(SPI_SDEPTH);

   // Bit 1 = accepted push, bit 0 = accepted pop.
   typedef enum logic [1:0] {
      FIFO_HOLD     = 2'b00,
      FIFO_POP      = 2'b01,
      FIFO_PUSH     = 2'b10,
      FIFO_PUSH_POP = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO for spi_shift_in: storage, wrap-bit pointers, full/empty
// decode and sticky overrun detection.
module spi_rx_fifo
   import spi_shift_in_pkg::*;
#(
   parameter int unsigned DWIDTH = SPI_SDEPTH,
   parameter int unsigned FDEPTH = SPI_FDEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   input  logic              ovr_clr,
   output logic [DWIDTH-1:0] data_out,
   output logic              valid_n,
   output logic              full_n,
   output logic              overrun_n
);

   localparam int unsigned AW = $clog2(FDEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DWIDTH-1:0] mem_q [FDEPTH];
   logic [DWIDTH-1:0] mem_d [FDEPTH];
   logic              ovr_q, ovr_d;
   logic              empty, full, pop_ok, push_ok, drop;
   fifo_op_e          op;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   always_comb begin
      pop_ok   = pop && !empty;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push_ok  = push && (!full || pop_ok);
      drop     = push && !push_ok;
      op       = fifo_op_e'({push_ok, pop_ok});
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      case (op)
         FIFO_PUSH: begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
         end
         FIFO_POP: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         FIFO_PUSH_POP: begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
            rd_ptr_d                = rd_ptr_q + 1'b1;
         end
         default: ;
      endcase
      ovr_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '1};
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
         ovr_q    <= ovr_d;
      end
   end

   assign data_out  = empty ? '1 : mem_q[rd_ptr_q[AW-1:0]];
   assign valid_n   = empty;
   assign full_n    = !full;
   assign overrun_n = !ovr_q;

endmodule

// File: rtl/spi_shift_in.sv
// SPI receive path: MSB-first shift register with bit counter and
// frame-error detection, feeding the spi_rx_fifo word queue.
module spi_shift_in
   import spi_shift_in_pkg::*;
#(
   parameter int unsigned SDEPTH = SPI_SDEPTH,
   parameter int unsigned FDEPTH = SPI_FDEPTH
) (
   input  logic              SPI_Clk,
   input  logic              SPI_ResetN,
   input  logic              SPI_CsN,
   input  logic              SPI_Sdi,
   input  logic              SPI_Data_AckN,
   input  logic              SPI_Ovr_ClrN,
   output logic [SDEPTH-1:0] SPI_Data_Out,
   output logic              SPI_Data_ValidN,
   output logic              SPI_FullN,
   output logic              SPI_OverrunN,
   output logic              SPI_FrameErrN
);

   localparam int unsigned CWIDTH = $clog2(SDEPTH);

   logic [SDEPTH-1:0] shift_q, shift_d;
   logic [CWIDTH-1:0] cnt_q, cnt_d;
   logic              frm_q, frm_d;
   logic              word_done;
   logic [SDEPTH-1:0] word;

   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word      = {shift_q[SDEPTH-2:0], SPI_Sdi};
      if (SPI_CsN) begin
         shift_d = '1;
         cnt_d   = '0;
      end else begin
         shift_d = word;
         if (cnt_q == CWIDTH'(SDEPTH - 1)) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // A new frame error takes priority over a clear on the same edge.
      frm_d = (SPI_CsN && (cnt_q != '0)) ? 1'b1 :
              (!SPI_Ovr_ClrN ? 1'b0 : frm_q);
   end

   always_ff @(posedge SPI_Clk or negedge SPI_ResetN) begin
      if (!SPI_ResetN) begin
         shift_q <= '1;
         cnt_q   <= '0;
         frm_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         frm_q   <= frm_d;
      end
   end

   assign SPI_FrameErrN = !frm_q;

   spi_rx_fifo #(
      .DWIDTH (SDEPTH),
      .FDEPTH (FDEPTH)
   ) u_fifo (
      .clk       (SPI_Clk),
      .rst_n     (SPI_ResetN),
      .push      (word_done),
      .push_data (word),
      .pop       (!SPI_Data_AckN),
      .ovr_clr   (!SPI_Ovr_ClrN),
      .data_out  (SPI_Data_Out),
      .valid_n   (SPI_Data_ValidN),
      .full_n    (SPI_FullN),
      .overrun_n (SPI_OverrunN)
   );

endmodule

// File: tb/tb_spi_shift_in.sv
// Self-checking bench for spi_shift_in: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_spi_shift_in;

   localparam int unsigned SDEPTH = 8;
   localparam int unsigned FDEPTH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              csn = 1'b1;
   logic              sdi = 1'b0;
   logic              ackn = 1'b1;
   logic              clrn = 1'b1;
   logic [SDEPTH-1:0] dout;
   logic              validn, fulln, ovrn, frmn;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   spi_shift_in #(
      .SDEPTH (SDEPTH),
      .FDEPTH (FDEPTH)
   ) dut (
      .SPI_Clk         (clk),
      .SPI_ResetN      (rst_n),
      .SPI_CsN         (csn),
      .SPI_Sdi         (sdi),
      .SPI_Data_AckN   (ackn),
      .SPI_Ovr_ClrN    (clrn),
      .SPI_Data_Out    (dout),
      .SPI_Data_ValidN (validn),
      .SPI_FullN       (fulln),
      .SPI_OverrunN    (ovrn),
      .SPI_FrameErrN   (frmn)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits received in the current frame, queue of words, flags.
   int unsigned       m_bits = 0;
   int unsigned       m_acc = 0;
   logic [SDEPTH-1:0] m_q[$];
   bit                m_ovr = 1'b0;
   bit                m_frm = 1'b0;

   task automatic model_step();
      bit                pop_ok, push, ovr_ev, frm_ev;
      logic [SDEPTH-1:0] w;
      if (!rst_n) begin
         m_bits = 0;
         m_acc  = 0;
         m_q.delete();
         m_ovr  = 1'b0;
         m_frm  = 1'b0;
         return;
      end
      pop_ok = !ackn && (m_q.size() != 0);
      push   = 1'b0;
      frm_ev = 1'b0;
      w      = '0;
      if (!csn) begin
         m_acc  = (m_acc * 2 + int'(sdi)) % (1 << SDEPTH);
         m_bits = m_bits + 1;
         if (m_bits == SDEPTH) begin
            push   = 1'b1;
            w      = m_acc[SDEPTH-1:0];
            m_bits = 0;
         end
      end else begin
         frm_ev = (m_bits != 0);
         m_bits = 0;
         m_acc  = 0;
      end
      ovr_ev = push && (m_q.size() == FDEPTH) && !pop_ok;
      if (pop_ok) void'(m_q.pop_front());
      if (push && !ovr_ev) m_q.push_back(w);
      m_ovr = ovr_ev ? 1'b1 : (!clrn ? 1'b0 : m_ovr);
      m_frm = frm_ev ? 1'b1 : (!clrn ? 1'b0 : m_frm);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(posedge clk);
      #2;
      check("data_out", dout, (m_q.size() != 0) ? m_q[0] : {SDEPTH{1'b1}});
      check("valid_n",  validn, (m_q.size() == 0));
      check("full_n",   fulln, (m_q.size() != FDEPTH));
      check("overrun_n", ovrn, !m_ovr);
      check("frame_err_n", frmn, !m_frm);
   end

   task automatic drive(input logic c, input logic d, input logic a, input logic cl);
      @(negedge clk);
      csn  = c;
      sdi  = d;
      ackn = a;
      clrn = cl;
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic ack();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ack_last, input bit clr_last);
      for (int i = 7; i >= 0; i--)
         drive(1'b0, b[i], (i == 0 && ack_last) ? 1'b0 : 1'b1,
               (i == 0 && clr_last) ? 1'b0 : 1'b1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst data_out", dout, 8'hFF);
      check("rst valid_n", validn, 1'b1);
      check("rst full_n", fulln, 1'b1);
      check("rst overrun_n", ovrn, 1'b1);
      check("rst frame_err_n", frmn, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single word, latency one clock after the last bit.
      send_byte(8'hA5, 0, 0);
      #1 check("a5 not yet valid", validn, 1'b1);
      idle();
      #1 check("a5 valid", validn, 1'b0);
      check("a5 data", dout, 8'hA5);
      ack();
      idle();
      #1 check("a5 popped", validn, 1'b1);

      // Overrun on third word; contents intact, drained in order.
      send_byte(8'h3C, 0, 0);
      send_byte(8'hC3, 0, 0);
      send_byte(8'h7E, 0, 0);
      idle();
      #1 check("ovr head", dout, 8'h3C);
      check("ovr full_n", fulln, 1'b0);
      check("ovr overrun_n", ovrn, 1'b0);
      ack();
      idle();
      #1 check("ovr second", dout, 8'hC3);
      ack();
      idle();
      #1 check("ovr drained", validn, 1'b1);
      check("ovr empty data", dout, 8'hFF);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      #1 check("ovr cleared", ovrn, 1'b1);

      // Full FIFO, push and pop on the same edge.
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      send_byte(8'h5A, 1, 0);
      idle();
      #1 check("pp no overrun", ovrn, 1'b1);
      check("pp head", dout, 8'h22);
      check("pp still full", fulln, 1'b0);
      ack();
      idle();
      #1 check("pp tail", dout, 8'h5A);
      ack();
      idle();

      // Aborted partial word, then realigned reception.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
      idle();
      send_byte(8'h81, 0, 0);
      idle();
      #1 check("frm flag", frmn, 1'b0);
      check("frm data", dout, 8'h81);
      ack();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      #1 check("frm cleared", frmn, 1'b1);

      // Clear and new overrun on the same edge: the overrun wins.
      send_byte(8'h44, 0, 0);
      send_byte(8'h55, 0, 0);
      send_byte(8'h66, 0, 0);
      send_byte(8'h77, 0, 1);
      idle();
      #1 check("ovr wins", ovrn, 1'b0);
      check("ovr wins head", dout, 8'h44);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      #1 check("ovr clr", ovrn, 1'b1);

      // Reset mid-word with a word queued.
      ack();
      ack();
      idle();
      send_byte(8'h34, 0, 0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
      #6 rst_n = 1'b0;
      #1 check("mid rst valid_n", validn, 1'b1);
      check("mid rst data_out", dout, 8'hFF);
      check("mid rst full_n", fulln, 1'b1);
      check("mid rst overrun_n", ovrn, 1'b1);
      check("mid rst frame_err_n", frmn, 1'b1);
      idle();
      idle();
      rst_n = 1'b1;
      send_byte(8'h12, 0, 0);
      idle();
      #1 check("post rst data", dout, 8'h12);
      check("post rst frame_err_n", frmn, 1'b1);
      ack();
      idle();

      // Random traffic; ack rate alternates to exercise both full and empty.
      for (int i = 0; i < 3000; i++) begin
         logic c, a, cl;
         c  = ($urandom_range(0, 39) == 0);
         a  = ((i / 500) % 2 == 0) ? ($urandom_range(0, 15) != 0)
                                   : ($urandom_range(0, 2) != 0);
         cl = ($urandom_range(0, 19) != 0);
         drive(c, 1'($urandom), a, cl);
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_shift_in.md
SPI_SHIFT_IN -- requirements
Module: spi_shift_in

Interface
REQ-001 Parameter SDEPTH, default 8, SHALL set the shift register and data word width in bits.
REQ-002 Parameter FDEPTH, default 2, SHALL set the receive FIFO depth in words; it SHALL be a power of two.
REQ-003 SPI_Clk  input  1  serial clock; all state SHALL be sampled and updated on posedge SPI_Clk.
REQ-004 SPI_ResetN  input  1  reset, asynchronous, active-low; clock SPI_Clk.
REQ-005 SPI_CsN  input  1  frame select, active-low, sampled synchronously; high = idle and bit-count realign.
REQ-006 SPI_Sdi  input  1  serial data in, MSB first.
REQ-007 SPI_Data_AckN  input  1  consumer pop, active-low, one word per clock while low.
REQ-008 SPI_Ovr_ClrN  input  1  overrun flag clear, active-low, synchronous.
REQ-009 SPI_Data_Out  output  SDEPTH  FIFO head word.
REQ-010 SPI_Data_ValidN  output  1  low when the FIFO holds at least one word.
REQ-011 SPI_FullN  output  1  low when the FIFO holds FDEPTH words.
REQ-012 SPI_OverrunN  output  1  sticky low after a word is dropped.
REQ-013 SPI_FrameErrN  output  1  sticky low after SPI_CsN rises mid-word.

Function
REQ-014 With SPI_CsN low, each posedge SHALL shift SPI_Sdi into shift[0], moving existing bits toward the MSB.
REQ-015 The bit counter SHALL count 0..SDEPTH-1 and wrap to 0 after the SDEPTH-th bit.
REQ-016 On the SDEPTH-th bit, the completed word {shift[SDEPTH-2:0], SPI_Sdi} SHALL be written to the FIFO on the same edge, with SPI_Data_ValidN low on the following cycle (latency 1 clock after the last bit).
REQ-017 With SPI_CsN high, the counter SHALL hold 0, shift SHALL hold all ones, and no word SHALL be written.
REQ-018 If SPI_CsN is sampled high while counter != 0, the partial word SHALL be discarded and SPI_FrameErrN SHALL go low.
REQ-019 SPI_Data_AckN low while SPI_Data_ValidN is low SHALL pop the head word on that edge.
REQ-020 SPI_Data_AckN low while the FIFO is empty SHALL be ignored.
REQ-021 A push and a pop on the same edge SHALL both take effect; occupancy SHALL stay unchanged and no overrun SHALL occur, even when the FIFO is full.
REQ-022 A push into a full FIFO with no simultaneous pop SHALL drop the new word, leave the FIFO contents intact, and drive SPI_OverrunN low.
REQ-023 SPI_OverrunN and SPI_FrameErrN SHALL return high only on SPI_Ovr_ClrN low or reset; if a clear and a new error occur on the same edge, the error SHALL win.
REQ-024 When the FIFO is empty, SPI_Data_Out SHALL be all ones.
REQ-025 FIFO read and write pointers SHALL be log2(FDEPTH)+1 bits wide and wrap modulo 2*FDEPTH.
REQ-026 Full SHALL be decoded as equal index bits with differing wrap bits.

Reset
REQ-027 On SPI_ResetN low, the block SHALL immediately set: counter 0, shift all ones, FIFO empty, SPI_Data_Out all ones, SPI_Data_ValidN 1, SPI_FullN 1, SPI_OverrunN 1, SPI_FrameErrN 1.
REQ-028 Reset asserted mid-word SHALL discard the partial word and all FIFO contents.
REQ-029 Reset SHALL not produce a FrameErr flag.

Structure
REQ-030 SDEPTH, FDEPTH and the counter width CWIDTH SHALL live in the shared SPI constants header, also used by spi_shift_out.
REQ-031 The FIFO SHALL be a sub-module, spi_rx_fifo, containing the storage, pointers, full/empty decode and overrun detection.
REQ-032 Shift register, bit counter and frame-error logic SHALL stay in spi_shift_in.

Verification
REQ-033 CsN low, send 0xA5 MSB first -> SPI_Data_ValidN low one clock after bit 8, SPI_Data_Out = 0xA5.
REQ-034 Send 0x3C, 0xC3, 0x7E with no ack -> FIFO holds 0x3C and 0xC3, SPI_FullN low, SPI_OverrunN low; then ack twice -> outputs 0x3C then 0xC3, then SPI_Data_ValidN high.
REQ-035 FIFO full and ack asserted on the 8th bit of 0x5A -> no overrun, head advances, 0x5A becomes the tail.
REQ-036 Raise CsN after 3 bits, then send 0x81 -> SPI_FrameErrN low, received word = 0x81 (no misalignment).
REQ-037 Assert reset after 5 bits with one word queued -> all outputs return to reset values immediately; the next 0x12 is received correctly.
REQ-038 Assert SPI_Ovr_ClrN while a new overrun occurs on the same edge -> SPI_OverrunN remains low.
